// File: rtl/mem_pkg.sv
// Shared codes, widths and reset-image helpers for the convolution tile/result memory.
package mem_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned TILE_BYTES = 16;
    localparam int unsigned FILT_BYTES = 9;
    localparam int unsigned TILE_W     = TILE_BYTES * BYTE_W;
    localparam int unsigned FILT_W     = FILT_BYTES * BYTE_W;
    localparam int unsigned RET_W      = 32;
    localparam int unsigned RES_W      = 2 * RET_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_STORE = 3'd2;

    localparam logic [2:0] CS_BUSY  = 3'd0;
    localparam logic [2:0] CS_DONE  = 3'd1;

    typedef enum logic [2:0] {
        MS_IDLE   = 3'd0,
        MS_READY  = 3'd1,
        MS_STORED = 3'd2,
        MS_FULL   = 3'd3
    } ms_e;

    // Reset image of tile t: byte k = (16*t + k) mod 256, row-major.
    function automatic logic [TILE_W-1:0] tile_init(input int unsigned t);
        logic [TILE_W-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < TILE_BYTES; k++) begin
            v[BYTE_W*k +: BYTE_W] = BYTE_W'(TILE_BYTES * t + k);
        end
        return v;
    endfunction

    // Reset image of the filter: byte j = j + 1.
    function automatic logic [FILT_W-1:0] filter_init();
        logic [FILT_W-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < FILT_BYTES; j++) begin
            v[BYTE_W*j +: BYTE_W] = BYTE_W'(j + 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/mem_result_ram.sv
// DEPTH x WIDTH result register file: synchronous write, async clear,
// registered read with write-through so a fresh write is visible on the same edge.
module mem_result_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_q
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (we) begin
                mem[wr_addr] <= wdata;
            end
            rd_q <= (we && (wr_addr == rd_addr)) ? wdata : mem[rd_addr];
        end
    end

endmodule

// File: rtl/memory_module.sv
// Tile/filter source and result store for the conv datapath; presents tiles
// on LOAD, captures conv results on each rising CS==DONE while in STORE.
module memory_module
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        state,
    input  logic [2:0]        CS,
    input  logic [RET_W-1:0]  inret22,
    input  logic [RET_W-1:0]  inret33,
    output logic [2:0]        MS,
    output logic [TILE_W-1:0] DATA,
    output logic [FILT_W-1:0] FILTER,
    output logic [RET_W-1:0]  ret22,
    output logic [RET_W-1:0]  ret33
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [TILE_W-1:0] tile_mem [DEPTH];
    logic [FILT_W-1:0] filter_q;
    logic [TILE_W-1:0] data_q;
    logic [FILT_W-1:0] filt_out_q;
    logic [AW-1:0]     ptr_q;
    logic [CW-1:0]     count_q;
    logic              cs_done_q;
    ms_e               ms_q;
    logic              store_c;
    logic [AW-1:0]     rd_addr_c;
    logic [RES_W-1:0]  res_q;

    // Store only on the rising edge of DONE, and never once the store is full.
    assign store_c = (state == ST_STORE) && (CS == CS_DONE) && !cs_done_q
                     && (ms_q != MS_FULL);

    // Read back the slot just written, otherwise the most recently written one.
    assign rd_addr_c = store_c ? ptr_q : (ptr_q - AW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < int'(DEPTH); t++) begin
                tile_mem[t] <= tile_init(32'(t));
            end
            filter_q <= filter_init();
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            count_q    <= '0;
            cs_done_q  <= 1'b0;
            ms_q       <= MS_IDLE;
            data_q     <= '0;
            filt_out_q <= '0;
        end else begin
            cs_done_q <= (CS == CS_DONE);
            case (state)
                ST_LOAD: begin
                    data_q     <= tile_mem[ptr_q];
                    filt_out_q <= filter_q;
                    if (ms_q != MS_FULL) begin
                        ms_q <= MS_READY;
                    end
                end
                ST_STORE: begin
                    if (store_c) begin
                        ptr_q   <= ptr_q + AW'(1);
                        count_q <= count_q + CW'(1);
                        ms_q    <= (count_q == CW'(DEPTH - 1)) ? MS_FULL : MS_STORED;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_result_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RES_W),
        .AW    (AW)
    ) u_res_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (store_c),
        .wr_addr (ptr_q),
        .wdata   ({inret22, inret33}),
        .rd_addr (rd_addr_c),
        .rd_q    (res_q)
    );

    assign MS     = ms_q;
    assign DATA   = data_q;
    assign FILTER = filt_out_q;
    assign ret22  = res_q[RES_W-1:RET_W];
    assign ret33  = res_q[RET_W-1:0];

endmodule

// File: tb/tb_memory_module.sv
// Directed plus randomized checks of memory_module against a transaction-level model.
module tb_memory_module;

    localparam int DEPTH = 4;

    logic         clk;
    logic         rst;
    logic [2:0]   state;
    logic [2:0]   CS;
    logic [31:0]  inret22;
    logic [31:0]  inret33;
    logic [2:0]   MS;
    logic [127:0] DATA;
    logic [71:0]  FILTER;
    logic [31:0]  ret22;
    logic [31:0]  ret33;

    memory_module #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .state   (state),
        .CS      (CS),
        .inret22 (inret22),
        .inret33 (inret33),
        .MS      (MS),
        .DATA    (DATA),
        .FILTER  (FILTER),
        .ret22   (ret22),
        .ret33   (ret33)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the controller should observe.
    int           m_ptr;
    int           m_cnt;
    bit           m_cs_prev;
    logic [2:0]   m_ms;
    logic [127:0] m_data;
    logic [71:0]  m_filt;
    logic [31:0]  m_r22;
    logic [31:0]  m_r33;
    logic [71:0]  filt_const;

    function automatic logic [127:0] tile_of(input int t);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'((16 * t + k) % 256);
        return v;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_cs_prev = 0;
        m_ms = 3'd0; m_data = '0; m_filt = '0; m_r22 = '0; m_r33 = '0;
    endtask

    task automatic model_step(input logic [2:0] st, input logic [2:0] cs,
                              input logic [31:0] a, input logic [31:0] b);
        bit full;
        full = (m_cnt >= DEPTH);
        if (st == 3'd1) begin
            m_data = tile_of(m_ptr);
            m_filt = filt_const;
            if (!full) m_ms = 3'd1;
        end
        if (st == 3'd2 && cs == 3'd1 && !m_cs_prev && !full) begin
            m_r22 = a;
            m_r33 = b;
            m_ptr = (m_ptr + 1) % DEPTH;
            m_cnt = m_cnt + 1;
            m_ms  = (m_cnt == DEPTH) ? 3'd3 : 3'd2;
        end
        m_cs_prev = (cs == 3'd1);
    endtask

    task automatic chk32(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk32({tag, ".MS"},     128'(MS),     128'(m_ms));
        chk32({tag, ".DATA"},   DATA,         m_data);
        chk32({tag, ".FILTER"}, 128'(FILTER), 128'(m_filt));
        chk32({tag, ".ret22"},  128'(ret22),  128'(m_r22));
        chk32({tag, ".ret33"},  128'(ret33),  128'(m_r33));
    endtask

    task automatic cyc(input string tag, input logic [2:0] st, input logic [2:0] cs,
                       input logic [31:0] a, input logic [31:0] b);
        state = st; CS = cs; inret22 = a; inret33 = b;
        @(posedge clk);
        model_step(st, cs, a, b);
        #1;
        check_all(tag);
    endtask

    // Async reset pulse placed between edges; checks the clear while rst is low.
    task automatic pulse_reset(input string tag);
        #1 rst = 1'b0;
        #1 model_reset();
        check_all(tag);
        #2 rst = 1'b1;
    endtask

    logic [127:0] exp_tile;
    logic [31:0]  ra, rb;
    int           guard;

    initial begin
        filt_const = 72'h090807060504030201;
        rst = 1'b0; state = 3'd0; CS = 3'd0; inret22 = '0; inret33 = '0;
        model_reset();

        // 1: reset and idle
        #3 check_all("reset");
        #9 rst = 1'b1;
        cyc("idle", 3'd0, 3'd0, 32'h0, 32'h0);

        // 2: first LOAD
        cyc("load0", 3'd1, 3'd0, 32'h0, 32'h0);
        exp_tile = 128'h0F0E0D0C0B0A09080706050403020100;
        chk32("load0.literal", DATA, exp_tile);
        chk32("load0.filt_literal", 128'(FILTER), 128'(72'h090807060504030201));

        // 3: one store from CS held three clocks
        cyc("st_pre", 3'd2, 3'd0, 32'h07707DF5, 32'h0000321C);
        for (int i = 0; i < 3; i++) cyc("st_hold", 3'd2, 3'd1, 32'h07707DF5, 32'h0000321C);
        chk32("st.ret22_literal", 128'(ret22), 128'(32'h07707DF5));
        chk32("st.ms_stored", 128'(MS), 128'(3'd2));

        // 4: LOAD shows tile 1
        cyc("load1", 3'd1, 3'd0, 32'h0, 32'h0);
        exp_tile = 128'h1F1E1D1C1B1A19181716151413121110;
        chk32("load1.literal", DATA, exp_tile);

        // 5: fill to FULL
        guard = 0;
        while (m_ms != 3'd3 && guard < 10) begin
            ra = $urandom; rb = $urandom;
            cyc("fill_ld", 3'd1, 3'd0, ra, rb);
            cyc("fill_lo", 3'd2, 3'd0, ra, rb);
            cyc("fill_hi", 3'd2, 3'd1, ra, rb);
            cyc("fill_hold", 3'd2, 3'd1, $urandom, $urandom);
            guard++;
        end
        chk32("fill.ms_full", 128'(MS), 128'(3'd3));
        cyc("full_lo", 3'd2, 3'd0, 32'hDEADBEEF, 32'hCAFEF00D);
        cyc("full_hi", 3'd2, 3'd1, 32'hDEADBEEF, 32'hCAFEF00D);
        cyc("full_ld", 3'd1, 3'd0, 32'h0, 32'h0);
        exp_tile = 128'h0F0E0D0C0B0A09080706050403020100;
        chk32("full_ld.tile0", DATA, exp_tile);
        chk32("full_ld.ms", 128'(MS), 128'(3'd3));

        // Randomized traffic with occasional resets
        pulse_reset("rnd_rst0");
        for (int n = 0; n < 400; n++) begin
            logic [2:0] st, cs;
            int r;
            r = int'($urandom_range(0, 9));
            st = (r < 4) ? 3'd2 : (r < 7) ? 3'd1 : (r < 8) ? 3'd0 : 3'($urandom_range(3, 7));
            r = int'($urandom_range(0, 9));
            cs = (r < 5) ? 3'd1 : (r < 8) ? 3'd0 : 3'($urandom_range(2, 7));
            cyc("rnd", st, cs, $urandom, $urandom);
            if (n % 97 == 96) pulse_reset("rnd_rst");
        end

        // 6: reset mid-STORE with CS high, then CS must drop before the next store
        cyc("r6_ld", 3'd1, 3'd0, 32'h0, 32'h0);
        cyc("r6_st", 3'd2, 3'd1, 32'h11111111, 32'h22222222);
        state = 3'd0;
        pulse_reset("r6_rst");
        cyc("r6_idle", 3'd0, 3'd1, 32'h0, 32'h0);
        cyc("r6_held", 3'd2, 3'd1, 32'h33333333, 32'h44444444);
        chk32("r6_held.ret22_zero", 128'(ret22), 128'(32'h0));
        cyc("r6_drop", 3'd2, 3'd0, 32'h55555555, 32'h66666666);
        cyc("r6_rise", 3'd2, 3'd1, 32'h55555555, 32'h66666666);
        chk32("r6_rise.ret33", 128'(ret33), 128'(32'h66666666));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
